// File: rtl/rdid_sequencer.sv
// rdid_sequencer
//   Control stage in front of the SPI RDID master. A rising edge on start
//   issues a single-cycle get_rdid pulse, then the block follows the master's
//   chip_select low and back high. Once the transaction ends, the 24-bit RDID
//   result is captured, split into its three ID bytes and compared with
//   EXPECTED_ID. A wait state that lasts too long raises a sticky timeout.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   IDLE         | waiting for a start edge
//   REQUEST      | get_rdid high for this single cycle
//   WAIT_CS_LOW  | waiting for the master to assert chip_select (low)
//   WAIT_CS_HIGH | waiting for the master to release chip_select (high)
//   CAPTURE      | latch rdid_data into the ID registers
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-high
//   start            request level (synchronous to clk); rising edge = read
//   chip_select      active-low chip select from the SPI master
//   rdid_data[23:0]  RDID result, stable once chip_select returns high
//   get_rdid         one-cycle start pulse to the master
//   manufacture_id   captured rdid_data[23:16]
//   memory_type      captured rdid_data[15:8]
//   memory_capacity  captured rdid_data[7:0]
//   id_valid         capture completed; held until the next request
//   id_match         captured ID equals EXPECTED_ID (qualified by id_valid)
//   busy             high in every state except IDLE
//   timeout          sticky; cleared by reset or the next accepted request

module rdid_sequencer #(
    parameter logic [23:0] EXPECTED_ID    = 24'h202015,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        chip_select,
    input  logic [23:0] rdid_data,
    output logic        get_rdid,
    output logic [7:0]  manufacture_id,
    output logic [7:0]  memory_type,
    output logic [7:0]  memory_capacity,
    output logic        id_valid,
    output logic        id_match,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        REQUEST      = 3'd1,
        WAIT_CS_LOW  = 3'd2,
        WAIT_CS_HIGH = 3'd3,
        CAPTURE      = 3'd4
    } state_t;

    // Comparing against one less than the limit makes a wait state time out
    // exactly TIMEOUT_CYCLES cycles after it is entered.
    localparam logic [15:0] COUNT_LIMIT = TIMEOUT_CYCLES - 16'd1;

    state_t      state, state_nxt;
    logic [15:0] count, count_nxt, count_inc;
    logic        start_d;
    logic        start_edge;

    logic        get_rdid_nxt;
    logic [7:0]  manufacture_id_nxt;
    logic [7:0]  memory_type_nxt;
    logic [7:0]  memory_capacity_nxt;
    logic        id_valid_nxt;
    logic        id_match_nxt;
    logic        busy_nxt;
    logic        timeout_nxt;

    // Registered edge: one cycle to detect, one more to reach REQUEST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_d    <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            start_d    <= start;
            start_edge <= start & ~start_d;
        end
    end

    // Saturating increment; the counter never wraps back to zero.
    assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            count           <= 16'd0;
            get_rdid        <= 1'b0;
            manufacture_id  <= 8'd0;
            memory_type     <= 8'd0;
            memory_capacity <= 8'd0;
            id_valid        <= 1'b0;
            id_match        <= 1'b0;
            busy            <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            get_rdid        <= get_rdid_nxt;
            manufacture_id  <= manufacture_id_nxt;
            memory_type     <= memory_type_nxt;
            memory_capacity <= memory_capacity_nxt;
            id_valid        <= id_valid_nxt;
            id_match        <= id_match_nxt;
            busy            <= busy_nxt;
            timeout         <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        count_nxt           = count;
        manufacture_id_nxt  = manufacture_id;
        memory_type_nxt     = memory_type;
        memory_capacity_nxt = memory_capacity;
        id_valid_nxt        = id_valid;
        id_match_nxt        = id_match;
        timeout_nxt         = timeout;

        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    id_valid_nxt = 1'b0;
                    id_match_nxt = 1'b0;
                    timeout_nxt  = 1'b0;
                    state_nxt    = REQUEST;
                end
            end
            REQUEST: begin
                count_nxt = 16'd0;
                state_nxt = WAIT_CS_LOW;
            end
            WAIT_CS_LOW: begin
                // A chip_select change on the limit cycle wins over timeout.
                if (!chip_select) begin
                    count_nxt = 16'd0;
                    state_nxt = WAIT_CS_HIGH;
                end else if (count == COUNT_LIMIT) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    count_nxt = count_inc;
                end
            end
            WAIT_CS_HIGH: begin
                if (chip_select) begin
                    state_nxt = CAPTURE;
                end else if (count == COUNT_LIMIT) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    count_nxt = count_inc;
                end
            end
            CAPTURE: begin
                manufacture_id_nxt  = rdid_data[23:16];
                memory_type_nxt     = rdid_data[15:8];
                memory_capacity_nxt = rdid_data[7:0];
                id_valid_nxt        = 1'b1;
                id_match_nxt        = (rdid_data == EXPECTED_ID);
                state_nxt           = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs follow the state being entered, so they line up with it.
        get_rdid_nxt = (state_nxt == REQUEST);
        busy_nxt     = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_rdid_sequencer.sv
// Testbench for rdid_sequencer: a behavioural SPI master answers each
// get_rdid pulse, the stimulus pushes the expected outcome of every request
// into a scoreboard queue and a monitor pops and compares on each completion.

module tb_rdid_sequencer;

    localparam logic [23:0] EXP_ID = 24'h202015;
    localparam int          TO     = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        chip_select;
    logic [23:0] rdid_data;
    logic        get_rdid;
    logic [7:0]  manufacture_id;
    logic [7:0]  memory_type;
    logic [7:0]  memory_capacity;
    logic        id_valid;
    logic        id_match;
    logic        busy;
    logic        timeout;

    rdid_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .chip_select     (chip_select),
        .rdid_data       (rdid_data),
        .get_rdid        (get_rdid),
        .manufacture_id  (manufacture_id),
        .memory_type     (memory_type),
        .memory_capacity (memory_capacity),
        .id_valid        (id_valid),
        .id_match        (id_match),
        .busy            (busy),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bytes;
        bit          to;
        bit          match;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          cyc       = 0;
    int          pulse_cnt = 0;
    int          done_cnt  = 0;
    int          g_cyc     = 0;
    logic [23:0] last_data = 24'h0;

    int          m_delay = 1;
    int          m_len   = 1;
    bit          m_dead  = 1'b0;
    bit          m_busy  = 1'b0;
    logic [23:0] m_data  = 24'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Behavioural SPI master: lowers chip_select m_delay cycles after the
    // get_rdid cycle, holds it low m_len cycles, then returns the ID.
    initial begin
        chip_select = 1'b1;
        rdid_data   = 24'h0;
        forever begin
            @(negedge clk);
            if (get_rdid && !m_dead) begin
                bit ab;
                ab     = 1'b0;
                m_busy = 1'b1;
                for (int i = 0; i < m_delay; i++) begin
                    @(posedge clk);
                    if (reset) begin ab = 1'b1; break; end
                end
                if (!ab) begin
                    #1;
                    chip_select = 1'b0;
                    rdid_data   = 24'($urandom);
                    for (int i = 0; i < m_len; i++) begin
                        @(posedge clk);
                        if (reset) begin ab = 1'b1; break; end
                    end
                    #1;
                    rdid_data   = ab ? 24'h0 : m_data;
                    chip_select = 1'b1;
                end
                m_busy = 1'b0;
            end
        end
    end

    // Monitor: checks every get_rdid pulse and every completion event.
    initial begin
        bit   prev_get, prev_v, prev_to;
        exp_t e;
        prev_get = 1'b0; prev_v = 1'b0; prev_to = 1'b0;
        forever begin
            @(negedge clk);
            if (get_rdid) begin
                pulse_cnt++;
                chk_eq("get_rdid_width", 32'(prev_get), 0);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL get_rdid_unexpected: got a pulse at cycle %0d, expected none", cyc);
                end else begin
                    chk_eq("start_to_get_rdid", 32'(cyc - sb[0].start_cyc), 2);
                end
                g_cyc = cyc;
            end
            if ((id_valid && !prev_v) || (timeout && !prev_to)) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL completion_unexpected: got completion at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk_eq("timeout",         32'(timeout),         32'(e.to));
                    chk_eq("id_valid",        32'(id_valid),        32'(!e.to));
                    chk_eq("id_match",        32'(id_match),        32'(e.match));
                    chk_eq("manufacture_id",  32'(manufacture_id),  32'(e.bytes[23:16]));
                    chk_eq("memory_type",     32'(memory_type),     32'(e.bytes[15:8]));
                    chk_eq("memory_capacity", 32'(memory_capacity), 32'(e.bytes[7:0]));
                    chk_eq("busy_after_done", 32'(busy),            0);
                    chk_eq("completion_latency", 32'(cyc - g_cyc),  32'(e.lat));
                end
            end
            prev_get = get_rdid;
            prev_v   = id_valid;
            prev_to  = timeout;
        end
    end

    task automatic wait_master_idle();
        for (int i = 0; i < 1000 && m_busy; i++) @(posedge clk);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) begin
            n_checks++;
            $display("FAIL completion_wait: no completion within 3000 cycles");
            sb.delete();
        end
        wait_master_idle();
    endtask

    // Reference: each wait state lasts until chip_select is seen, or ends in
    // timeout after TO cycles; REQUEST and CAPTURE take one cycle each.
    task automatic issue(input logic [23:0] data, input int d, input int len,
                         input bit dead, input int hold, input int repulse);
        exp_t e;
        int   p0, d0;
        wait_master_idle();
        m_data = data; m_delay = d; m_len = len; m_dead = dead;
        if (dead || d > TO) begin
            e.to = 1'b1; e.lat = 1 + TO;
        end else if (len > TO) begin
            e.to = 1'b1; e.lat = 1 + d + TO;
        end else begin
            e.to = 1'b0; e.lat = 1 + d + len + 1;
        end
        e.bytes = e.to ? last_data : data;
        e.match = !e.to && (data == EXP_ID);
        if (!e.to) last_data = data;
        p0 = pulse_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        e.start_cyc = cyc;
        sb.push_back(e);
        start = 1'b1;
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
        if (repulse > 0) begin
            repeat (repulse) @(posedge clk);
            #1 start = 1'b1;
            repeat (2) @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(d0);
        chk_eq("get_rdid_pulses", 32'(pulse_cnt - p0), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_get_rdid",  32'(get_rdid),        0);
        chk_eq("rst_manuf",     32'(manufacture_id),  0);
        chk_eq("rst_type",      32'(memory_type),     0);
        chk_eq("rst_capacity",  32'(memory_capacity), 0);
        chk_eq("rst_id_valid",  32'(id_valid),        0);
        chk_eq("rst_id_match",  32'(id_match),        0);
        chk_eq("rst_busy",      32'(busy),            0);
        chk_eq("rst_timeout",   32'(timeout),         0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        issue(EXP_ID,       1,   66, 1'b0, 2,   0);   // nominal matching read
        issue(24'hFFFFFF,   1,   66, 1'b0, 2,   0);   // non-matching ID
        issue(EXP_ID,       1,   40, 1'b0, 500, 0);   // start held high
        issue(24'h123456,   1,   30, 1'b0, 2,   0);   // second read after re-rise
        issue(24'hABCDEF,   1,   10, 1'b1, 2,   0);   // master never responds
        issue(24'h0C0FFE,   255, 5,  1'b0, 2,   0);   // cs falls on limit cycle
        issue(24'h555555,   256, 3,  1'b0, 2,   0);   // one cycle too late
        issue(24'h202015,   1,   255, 1'b0, 2,  0);   // cs rises on limit cycle
        issue(24'h777777,   1,   256, 1'b0, 2,  0);   // cs held low too long
        issue(EXP_ID,       1,   60, 1'b0, 2,   20);  // start re-pulsed mid-read

        // Reset in the middle of WAIT_CS_HIGH.
        wait_master_idle();
        m_data = 24'h998877; m_delay = 1; m_len = 66; m_dead = 1'b0;
        begin
            exp_t e;
            e.to = 1'b0; e.match = 1'b0; e.bytes = 24'h998877; e.lat = 68;
            p0 = pulse_cnt;
            @(posedge clk); #1;
            e.start_cyc = cyc;
            sb.push_back(e);
            start = 1'b1;
            repeat (2) @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 50 && pulse_cnt == p0; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_eq("busy_before_reset", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk_eq("midrst_get_rdid", 32'(get_rdid),        0);
        chk_eq("midrst_manuf",    32'(manufacture_id),  0);
        chk_eq("midrst_type",     32'(memory_type),     0);
        chk_eq("midrst_capacity", 32'(memory_capacity), 0);
        chk_eq("midrst_id_valid", 32'(id_valid),        0);
        chk_eq("midrst_id_match", 32'(id_match),        0);
        chk_eq("midrst_busy",     32'(busy),            0);
        chk_eq("midrst_timeout",  32'(timeout),         0);
        sb.delete();
        last_data = 24'h0;
        repeat (3) @(posedge clk);
        wait_master_idle();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        issue(24'h00FFAA, 1, 10, 1'b1, 2, 0);         // timeout keeps reset bytes
        issue(EXP_ID,     1, 66, 1'b0, 2, 0);         // normal after reset

        for (int n = 0; n < 12; n++) begin
            logic [23:0] data;
            bit          dead;
            data = ($urandom_range(0, 1) == 1) ? EXP_ID : 24'($urandom);
            dead = ($urandom_range(0, 5) == 0);
            issue(data, int'($urandom_range(1, 8)), int'($urandom_range(1, 100)),
                  dead, int'($urandom_range(1, 4)), 0);
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
